// File: rtl/mdu_pkg.sv
// Shared types and helpers for the multiply/divide unit.
// Optional divider is enabled with `define MDU_DIV_EN.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6,
    MDU_RSVD  = 3'd7
  } mdu_op_e;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_RUN  = 1'b1
  } mdu_state_e;

  function automatic int cnt_width(
    input int mult_c,
    input int div_c
  );
    int m;
    m = (mult_c > div_c) ? mult_c : div_c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational product / quotient-remainder generator.
// Divider present only when `define MDU_DIV_EN is set.
module mdu_calc
  import mdu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic                  run_o,
  output logic                  we_o,
  output logic [DATA_WIDTH-1:0] hi_o,
  output logic [DATA_WIDTH-1:0] lo_o
);

  localparam int W = DATA_WIDTH;

  mdu_op_e op;
  assign op = mdu_op_e'(op_i);

  logic signed [2*W-1:0] prod_s;
  logic        [2*W-1:0] prod_u;

  assign prod_s = $signed({{W{a_i[W-1]}}, a_i})
                * $signed({{W{b_i[W-1]}}, b_i});
  assign prod_u = {{W{1'b0}}, a_i} * {{W{1'b0}}, b_i};

`ifdef MDU_DIV_EN
  logic         a_neg;
  logic         b_neg;
  logic [W-1:0] a_mag;
  logic [W-1:0] b_mag;
  logic [W-1:0] q_mag;
  logic [W-1:0] r_mag;
  logic [W-1:0] q_s;
  logic [W-1:0] r_s;
  logic [W-1:0] bu_nz;
  logic [W-1:0] q_u;
  logic [W-1:0] r_u;

  // Magnitude divide; MIN/-1 wraps back to MIN with rem 0 naturally.
  // A zero divisor is replaced by 1 only to keep the values defined.
  assign a_neg = a_i[W-1];
  assign b_neg = b_i[W-1];
  assign a_mag = a_neg ? (~a_i + 1'b1) : a_i;
  assign b_mag = (b_i == '0) ? W'(1)
               : (b_neg ? (~b_i + 1'b1) : b_i);
  assign q_mag = a_mag / b_mag;
  assign r_mag = a_mag % b_mag;
  assign q_s   = (a_neg ^ b_neg) ? (~q_mag + 1'b1) : q_mag;
  assign r_s   = a_neg ? (~r_mag + 1'b1) : r_mag;

  assign bu_nz = (b_i == '0) ? W'(1) : b_i;
  assign q_u   = a_i / bu_nz;
  assign r_u   = a_i % bu_nz;
`endif

  always_comb begin
    run_o = 1'b0;
    we_o  = 1'b0;
    hi_o  = '0;
    lo_o  = '0;
    unique case (op)
      MDU_MULT: begin
        run_o        = 1'b1;
        we_o         = 1'b1;
        {hi_o, lo_o} = prod_s;
      end
      MDU_MULTU: begin
        run_o        = 1'b1;
        we_o         = 1'b1;
        {hi_o, lo_o} = prod_u;
      end
`ifdef MDU_DIV_EN
      MDU_DIV: begin
        run_o = 1'b1;
        we_o  = (b_i != '0);
        hi_o  = r_s;
        lo_o  = q_s;
      end
      MDU_DIVU: begin
        run_o = 1'b1;
        we_o  = (b_i != '0);
        hi_o  = r_u;
        lo_o  = q_u;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// Divider is built only with `define MDU_DIV_EN.
module mdu
  import mdu_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            mdu_op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] hi_out,
  output logic [DATA_WIDTH-1:0] lo_out
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = cnt_width(MULT_CYCLES, DIV_CYCLES);

  mdu_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  hi_q, hi_d;
  logic [W-1:0]  lo_q, lo_d;
  logic [W-1:0]  pend_hi_q, pend_hi_d;
  logic [W-1:0]  pend_lo_q, pend_lo_d;
  logic          pend_we_q, pend_we_d;

  logic          c_run;
  logic          c_we;
  logic [W-1:0]  c_hi;
  logic [W-1:0]  c_lo;
  logic          is_div;

  mdu_calc #(
    .DATA_WIDTH(W)
  ) u_calc (
    .op_i (mdu_op),
    .a_i  (a),
    .b_i  (b),
    .run_o(c_run),
    .we_o (c_we),
    .hi_o (c_hi),
    .lo_o (c_lo)
  );

  assign is_div = (mdu_op == MDU_DIV) || (mdu_op == MDU_DIVU);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_we_d = pend_we_q;
    unique case (state_q)
      MDU_IDLE: begin
        if (start) begin
          unique case (1'b1)
            c_run: begin
              state_d   = MDU_RUN;
              cnt_d     = is_div ? CW'(DIV_CYCLES)
                                 : CW'(MULT_CYCLES);
              pend_hi_d = c_hi;
              pend_lo_d = c_lo;
              pend_we_d = c_we;
            end
            (mdu_op == MDU_MTHI): hi_d = a;
            (mdu_op == MDU_MTLO): lo_d = a;
            default: ;
          endcase
        end
      end
      MDU_RUN: begin
        // start is ignored here; control stalls on busy
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = MDU_IDLE;
          if (pend_we_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= MDU_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_we_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_we_q <= pend_we_d;
    end
  end

  assign busy   = (state_q == MDU_RUN);
  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed cases plus random ops
// against an arithmetic reference model of HI/LO.
module tb_mdu;

  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;
`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   mdu_op = 3'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic [W-1:0] hi_out;
  logic [W-1:0] lo_out;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;

  always #5 clk = ~clk;

  mdu #(
    .DATA_WIDTH (W),
    .MULT_CYCLES(MC),
    .DIV_CYCLES (DC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .mdu_op(mdu_op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .hi_out(hi_out),
    .lo_out(lo_out)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic bsy,
                         input logic [W-1:0] h, input logic [W-1:0] l);
    chk({tag, "/busy"}, W'(busy), W'(bsy));
    chk({tag, "/hi"}, hi_out, h);
    chk({tag, "/lo"}, lo_out, l);
  endtask

  task automatic model(input logic [2:0] op, input logic [W-1:0] x,
                       input logic [W-1:0] y);
    longint sx, sy, p;
    logic [63:0] pu;
    sx = longint'(signed'(x));
    sy = longint'(signed'(y));
    case (op)
      3'd1: begin
        p = sx * sy;
        exp_hi = p[63:32];
        exp_lo = p[31:0];
      end
      3'd2: begin
        pu = {32'd0, x} * {32'd0, y};
        exp_hi = pu[63:32];
        exp_lo = pu[31:0];
      end
      3'd3: if (DIV_EN && y != 0) begin
        p = sx / sy;
        exp_lo = p[31:0];
        p = sx % sy;
        exp_hi = p[31:0];
      end
      3'd4: if (DIV_EN && y != 0) begin
        exp_lo = x / y;
        exp_hi = x % y;
      end
      3'd5: exp_hi = x;
      3'd6: exp_lo = x;
      default: ;
    endcase
  endtask

  function automatic int lat(input logic [2:0] op);
    if (op == 3'd1 || op == 3'd2) return MC;
    if (op == 3'd3 || op == 3'd4) return DIV_EN ? DC : 0;
    return 0;
  endfunction

  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [W-1:0] x, input logic [W-1:0] y);
    int n;
    logic [W-1:0] ohi, olo;
    ohi = exp_hi;
    olo = exp_lo;
    n = lat(op);
    @(negedge clk);
    start = 1'b1;
    mdu_op = op;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    mdu_op = 3'd0;
    model(op, x, y);
    for (int k = 0; k < n; k++) begin
      chk_all(tag, 1'b1, ohi, olo);
      @(posedge clk);
      #1;
    end
    chk_all(tag, 1'b0, exp_hi, exp_lo);
  endtask

  initial begin
    logic [2:0] rop;
    logic [W-1:0] ra, rb;
    logic [W-1:0] ohi, olo;

    #1 reset = 1'b0;
    #1 chk_all("reset", 1'b0, '0, '0);
    @(negedge clk);
    reset = 1'b1;

    run_op("mult", 3'd1, 32'hFFFF_FFFE, 32'd3);
    run_op("multu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("div", 3'd3, 32'hFFFF_FFF9, 32'd2);
    run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("mthi", 3'd5, 32'h0000_1234, 32'd0);
    run_op("mtlo", 3'd6, 32'h0000_5678, 32'd0);
    run_op("divu0", 3'd4, 32'h0000_0099, 32'd0);
    run_op("div0", 3'd3, 32'h0000_0099, 32'd0);
    run_op("rsvd", 3'd7, 32'h1111_1111, 32'd5);

    // start during RUN must be ignored, mtlo included
    ohi = exp_hi;
    olo = exp_lo;
    @(negedge clk);
    start = 1'b1;
    mdu_op = 3'd1;
    a = 32'd3;
    b = 32'd4;
    @(posedge clk);
    #1;
    model(3'd1, 32'd3, 32'd4);
    for (int k = 0; k < MC; k++) begin
      if (k == 0) begin
        mdu_op = 3'd6;
        a = 32'h0000_AAAA;
      end else if (k == 1) begin
        mdu_op = 3'd1;
        a = 32'd7;
        b = 32'd7;
      end else begin
        start = 1'b0;
        mdu_op = 3'd0;
      end
      chk_all("ignore", 1'b1, ohi, olo);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    chk_all("ignore_end", 1'b0, exp_hi, exp_lo);
    @(posedge clk);
    #1 chk_all("ignore_hold", 1'b0, exp_hi, exp_lo);

    // reset mid-operation aborts without commit
    @(negedge clk);
    start = 1'b1;
    mdu_op = 3'd1;
    a = 32'd9;
    b = 32'd9;
    @(posedge clk);
    #1 start = 1'b0;
    mdu_op = 3'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    #1 chk_all("rst_mid", 1'b0, '0, '0);
    @(negedge clk);
    reset = 1'b1;
    repeat (MC + 3) @(posedge clk);
    #1 chk_all("rst_after", 1'b0, '0, '0);

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: begin
          ra = 32'h8000_0000;
          rb = 32'hFFFF_FFFF;
        end
        2: rb = 32'($urandom_range(1, 9));
        default: ;
      endcase
      run_op("rand", rop, ra, rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdu.md
# mdu

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers, sitting beside the ALU in the execute stage of the CPU datapath. Accepts one operation per start pulse, computes signed or unsigned product, or quotient and remainder, and holds `busy` for a configurable latency. Then it commits the result to HI/LO. The pipeline control uses `busy` to stall later MDU-dependent instructions.

## Interface
- `DATA_WIDTH`, 32: width of operands, HI and LO.
- `MULT_CYCLES`, 5: cycles `busy` stays high for mult/multu; must be ≥1.
- `DIV_CYCLES`, 10: cycles `busy` stays high for div/divu; must be ≥1.
- `clk`  input  1  system clock, rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `start`  input  1  one-cycle request; sampled with `mdu_op`, `a` and `b`.
- `mdu_op`  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved.
- `a`  input  DATA_WIDTH  rs operand and dividend.
- `b`  input  DATA_WIDTH  rt operand and divisor.
- `busy`  output  1  operation in flight.
- `hi_out`  output  DATA_WIDTH  current HI.
- `lo_out`  output  DATA_WIDTH  current LO.

## Operation
- Reset (async, `reset`=0) forces HI=0, LO=0, `busy`=0, counter=0 and pending result=0. Reset mid-operation aborts the operation, and no commit happens.
- States:
  - IDLE (`busy`=0).
  - RUN (`busy`=1, counter counting down).
- IDLE with `start`=1:
  - mult/multu/div/divu: the result is computed from `a` and `b` and latched into the pending HI/LO registers. The counter is loaded with MULT_CYCLES or DIV_CYCLES, and the state goes to RUN.
  - mthi: HI←`a` at the same edge, state stays IDLE. mtlo does the same for LO.
  - op 0 or 7: no effect.
- RUN: the counter decrements each edge. At the edge where counter==1, pending HI/LO is committed to HI/LO and the state returns to IDLE.
- `start` during RUN is ignored entirely, including mthi/mtlo. Control must stall instead of issuing.
- mult: signed 2·DATA_WIDTH product. HI = upper half, LO = lower half. multu is the same, unsigned.
- div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend. Overflow case a=MIN, b=−1 gives LO=MIN, HI=0. divu is the same, unsigned.
- Divide by zero (b=0, div or divu): HI/LO unchanged at commit; `busy` timing is unchanged.
- HI/LO outputs always show committed values; they never show pending ones.

## Timing
- `start` is sampled at edge E0. `busy` goes high after E0 and stays high for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES).
- HI/LO update at edge E0+N, and `busy` falls at the same edge.
- A new `start` is accepted in the first cycle after `busy` falls, which gives back-to-back throughput of one op per N+1 cycles.
- mthi/mtlo take 1 cycle: the value is visible after E0 and `busy` never asserts.
- All outputs are registered. There is no combinational path from the inputs to `busy`, `hi_out` or `lo_out`.

## Configuration
- `MDU_DIV_EN` defined: div/divu are implemented as above.
- `MDU_DIV_EN` undefined:
  - No divider logic is synthesised.
  - `mdu_op` 3 and 4 behave as op 0: no busy, HI/LO unchanged.
  - DIV_CYCLES is unused.

## Structure
- Package `mdu_pkg` holds:
  - op encodings `MDU_NONE`…`MDU_MTLO`;
  - the state enum `MDU_IDLE`/`MDU_RUN`;
  - the counter width function clog2(max(MULT_CYCLES, DIV_CYCLES)+1).
- One sub-module, `mdu_calc`: combinational generator of {pending_hi, pending_lo} from `mdu_op`, `a` and `b`. It includes the signed/unsigned and divide-by-zero/overflow rules, and the `MDU_DIV_EN` gating.
- The top level `mdu` contains the FSM, the counter, and the pending and HI/LO registers.

## Test plan
- mult, a=0xFFFFFFFE (−2), b=3 (defaults) → `busy` high for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu, a=0xFFFFFFFF, b=0xFFFFFFFF → after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- div, a=−7 (0xFFFFFFF9), b=2 → `busy` 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then div a=0x80000000, b=−1 → LO=0x80000000, HI=0.
- divu with b=0 after mthi 0x1234, mtlo 0x5678 → `busy` 10 cycles, HI=0x1234, LO=0x5678 unchanged. Repeat without `MDU_DIV_EN` → `busy` stays 0.
- mult issued, then mtlo 0xAAAA and a second mult asserted during RUN → both ignored; the first mult's result commits at cycle 5.
- mult issued, `reset` pulsed low at cycle 3 → `busy`=0 and HI=LO=0 immediately; no commit afterwards.
